// File: rtl/counter_stream_encoder_if.sv
// counter_stream_encoder_if
// Sample stream handshake into the counter stream encoder.
//   sample_in    : signed 9-bit sample, two's complement
//   sample_valid : sample_in carries a sample this cycle
//   sample_ready : encoder accepts the sample this cycle
// master = sample producer, slave = encoder.
interface counter_stream_encoder_if;
  logic signed [8:0] sample_in;
  logic              sample_valid;
  logic              sample_ready;

  modport master (
    output sample_in,
    output sample_valid,
    input  sample_ready
  );

  modport slave (
    input  sample_in,
    input  sample_valid,
    output sample_ready
  );
endinterface

// File: rtl/counter_stream_encoder.sv
// counter_stream_encoder
// Turns one signed sample per frame (2^N_DIV cycles of CLK_24M) into a
// counter_p/counter_n pair whose difference is the running sum of the
// samples, so a receive integrator/decimator/double-difference chain
// reproduces the original sample stream.
// Ports:
//   CLK_24M      : system clock
//   reset        : asynchronous, active-low reset
//   enable       : run enable; all state holds while low
//   s_if         : sample stream (slave side: sample_in/valid in, ready out)
//   clear_flags  : synchronous clear of the sticky underrun flag
//   counter_p    : COMMON + accumulator, registered
//   counter_n    : COMMON, registered
//   frame_strobe : high in the cycle where the phase counter is 0
//   underrun     : sticky, a frame boundary found the buffer empty
module counter_stream_encoder #(
  parameter int          N_DIV  = 3,
  parameter logic [11:0] COMMON = 12'd1024
) (
  input  logic                            CLK_24M,
  input  logic                            reset,
  input  logic                            enable,
  counter_stream_encoder_if.slave         s_if,
  input  logic                            clear_flags,
  output logic [11:0]                     counter_p,
  output logic [11:0]                     counter_n,
  output logic                            frame_strobe,
  output logic                            underrun
);

  localparam logic [N_DIV-1:0] PHASE_LAST = {N_DIV{1'b1}};
  localparam logic [N_DIV-1:0] PHASE_ONE  = {{(N_DIV-1){1'b0}}, 1'b1};

  logic [N_DIV-1:0]  phase_r;
  logic signed [8:0] fifo_r [2];
  logic              rd_ptr_r;
  logic [1:0]        count_r;
  logic [11:0]       acc_r;
  logic [11:0]       counter_p_r;
  logic [11:0]       counter_n_r;
  logic              frame_strobe_r;
  logic              underrun_r;

  logic              sample_ready_s;
  logic              boundary_s;
  logic              push_s;
  logic              pop_s;
  logic              wr_ptr_s;
  logic signed [8:0] head_s;
  logic [11:0]       y_s;
  logic [1:0]        count_nxt_s;

  // Handshake, frame boundary detection and FIFO bookkeeping.
  always_comb begin
    sample_ready_s = 1'b0;
    boundary_s     = 1'b0;
    y_s            = 12'd0;
    count_nxt_s    = count_r;
    if (enable && (count_r < 2'd2)) begin
      sample_ready_s = 1'b1;
    end else begin
      sample_ready_s = 1'b0;
    end
    if (enable && (phase_r == PHASE_LAST)) begin
      boundary_s = 1'b1;
    end else begin
      boundary_s = 1'b0;
    end
    push_s   = s_if.sample_valid && sample_ready_s;
    pop_s    = boundary_s && (count_r != 2'd0);
    // With at most two entries the write slot is the read slot offset by count.
    wr_ptr_s = rd_ptr_r ^ count_r[0];
    head_s   = fifo_r[rd_ptr_r];
    if (pop_s) begin
      y_s = {{3{head_s[8]}}, head_s};
    end else begin
      y_s = 12'd0;
    end
    case ({push_s, pop_s})
      2'b10:   count_nxt_s = count_r + 2'd1;
      2'b01:   count_nxt_s = count_r - 2'd1;
      default: count_nxt_s = count_r;
    endcase
  end

  assign s_if.sample_ready = sample_ready_s;

  // Phase, FIFO, accumulator, output registers and sticky underrun flag.
  always_ff @(posedge CLK_24M or negedge reset) begin
    if (!reset) begin
      phase_r        <= {N_DIV{1'b0}};
      fifo_r[0]      <= 9'sd0;
      fifo_r[1]      <= 9'sd0;
      rd_ptr_r       <= 1'b0;
      count_r        <= 2'd0;
      acc_r          <= 12'd0;
      counter_p_r    <= COMMON;
      counter_n_r    <= COMMON;
      frame_strobe_r <= 1'b0;
      underrun_r     <= 1'b0;
    end else begin
      if (enable) begin
        phase_r <= phase_r + PHASE_ONE;
        if (push_s) begin
          fifo_r[wr_ptr_s] <= s_if.sample_in;
        end
        if (pop_s) begin
          rd_ptr_r <= ~rd_ptr_r;
        end
        count_r     <= count_nxt_s;
        // Wraps modulo 4096 on purpose: the receiver only sees differences.
        acc_r       <= acc_r + y_s;
        counter_p_r <= COMMON + acc_r;
        counter_n_r <= COMMON;
      end
      frame_strobe_r <= boundary_s;
      // Set takes priority over a coincident clear.
      if (boundary_s && (count_r == 2'd0)) begin
        underrun_r <= 1'b1;
      end else if (clear_flags) begin
        underrun_r <= 1'b0;
      end
    end
  end

  assign counter_p    = counter_p_r;
  assign counter_n    = counter_n_r;
  assign frame_strobe = frame_strobe_r;
  assign underrun     = underrun_r;

endmodule

// File: tb/tb_counter_stream_encoder.sv
// tb_counter_stream_encoder
// Directed stimulus for counter_stream_encoder. A queue-based model of the
// encoder's behaviour tracks the expected outputs and is compared against
// the DUT on every falling clock edge; hand-computed literal values pin the
// model at key points of each scenario.
module tb_counter_stream_encoder;

  logic        CLK_24M;
  logic        reset;
  logic        enable;
  logic        clear_flags;
  logic [11:0] counter_p;
  logic [11:0] counter_n;
  logic        frame_strobe;
  logic        underrun;

  counter_stream_encoder_if s_if ();

  counter_stream_encoder #(
    .N_DIV (3),
    .COMMON(12'd1024)
  ) dut (
    .CLK_24M     (CLK_24M),
    .reset       (reset),
    .enable      (enable),
    .s_if        (s_if),
    .clear_flags (clear_flags),
    .counter_p   (counter_p),
    .counter_n   (counter_n),
    .frame_strobe(frame_strobe),
    .underrun    (underrun)
  );

  initial CLK_24M = 1'b0;
  always #20 CLK_24M = ~CLK_24M;

  int pass_cnt = 0;
  int total_cnt = 0;
  bit started = 1'b0;

  // model state
  int q[$];
  int m_phase = 0;
  int m_acc = 0;
  int m_cp = 1024;
  int m_cn = 1024;
  int m_fs = 0;
  int m_ur = 0;

  task automatic chk(input string nm, input int act, input int exp);
    total_cnt++;
    if (act == exp) pass_cnt++;
    else $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
  endtask

  task automatic model_step();
    int  y;
    bit  bnd;
    bit  push;
    bit  set_ur;
    if (!reset) begin
      q.delete();
      m_phase = 0; m_acc = 0; m_cp = 1024; m_cn = 1024; m_fs = 0; m_ur = 0;
    end else begin
      bnd    = enable && (m_phase == 7);
      push   = enable && s_if.sample_valid && (q.size() < 2);
      set_ur = bnd && (q.size() == 0);
      if (enable) begin
        m_cp = (1024 + m_acc) % 4096;
        m_cn = 1024;
        y = 0;
        if (bnd && q.size() > 0) y = q.pop_front();
        m_acc = (m_acc + y) & 4095;
        if (push) q.push_back(int'(s_if.sample_in));
        m_phase = (m_phase + 1) % 8;
      end
      m_fs = bnd;
      if (set_ur) m_ur = 1;
      else if (clear_flags) m_ur = 0;
    end
  endtask

  initial forever begin
    @(posedge CLK_24M or negedge reset);
    model_step();
  end

  initial forever begin
    @(negedge CLK_24M);
    if (started) begin
      chk("counter_p", int'(counter_p), m_cp);
      chk("counter_n", int'(counter_n), m_cn);
      chk("frame_strobe", int'(frame_strobe), m_fs);
      chk("underrun", int'(underrun), m_ur);
      chk("sample_ready", int'(s_if.sample_ready), int'(enable && q.size() < 2));
    end
  end

  // one clock: drive inputs now, return just after the next falling edge
  task automatic cyc(input logic v, input int s);
    s_if.sample_valid = v;
    s_if.sample_in    = 9'(s);
    @(negedge CLK_24M);
    #1;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cyc(1'b0, 0);
  endtask

  task automatic do_reset();
    reset = 1'b0;
    enable = 1'b0;
    clear_flags = 1'b0;
    cyc(1'b0, 0);
    cyc(1'b0, 0);
    reset = 1'b1;
    enable = 1'b1;
  endtask

  initial begin
    int n;
    reset = 1'b0;
    enable = 1'b0;
    clear_flags = 1'b0;
    s_if.sample_valid = 1'b0;
    s_if.sample_in = 9'sd0;
    @(negedge CLK_24M);
    #1;
    started = 1'b1;

    // A: idle stream, underrun at first boundary, clear drops it
    do_reset();
    chk("rst_cp", int'(counter_p), 1024);
    chk("rst_cn", int'(counter_n), 1024);
    chk("rst_fs", int'(frame_strobe), 0);
    chk("rst_ur", int'(underrun), 0);
    idle(7);
    chk("A_fs_e7", int'(frame_strobe), 0);
    chk("A_ur_e7", int'(underrun), 0);
    idle(1);
    chk("A_fs_e8", int'(frame_strobe), 1);
    chk("A_ur_e8", int'(underrun), 1);
    clear_flags = 1'b1;
    idle(1);
    clear_flags = 1'b0;
    chk("A_ur_clr", int'(underrun), 0);
    idle(7);
    chk("A_ur_e16", int'(underrun), 1);

    // B: push 5, then zeros every frame
    do_reset();
    cyc(1'b1, 5);
    idle(7);
    chk("B_cp_e8", int'(counter_p), 1024);
    idle(1);
    chk("B_cp_e9", int'(counter_p), 1029);
    for (int f = 0; f < 3; f++) begin
      cyc(1'b1, 0);
      idle(7);
    end
    chk("B_cp_end", int'(counter_p), 1029);
    chk("B_cn_end", int'(counter_n), 1024);
    chk("B_ur_end", int'(underrun), 0);

    // C: +1, -1, 0
    do_reset();
    cyc(1'b1, 1);
    idle(7);
    cyc(1'b1, -1);
    idle(3);
    chk("C_cp_e12", int'(counter_p), 1025);
    idle(4);
    cyc(1'b1, 0);
    chk("C_cp_e17", int'(counter_p), 1024);
    idle(8);
    chk("C_cp_e25", int'(counter_p), 1024);
    chk("C_ur_e25", int'(underrun), 0);

    // D: 255 every frame for 20 frames, wraps modulo 4096
    do_reset();
    for (int k = 0; k < 160; k++) begin
      cyc((k % 8) == 0, 255);
      if (k == 8) chk("D_cp_f1", int'(counter_p), 1279);
    end
    cyc(1'b0, 0);
    chk("D_cp_f20", int'(counter_p), 2028);
    chk("D_ur", int'(underrun), 0);

    // E: backpressure with three samples inside one frame
    do_reset();
    cyc(1'b1, 10);
    cyc(1'b1, 20);
    chk("E_ready_full", int'(s_if.sample_ready), 0);
    n = 0;
    while (!s_if.sample_ready && n < 20) begin
      cyc(1'b1, 30);
      n++;
    end
    chk("E_ready_wait", n, 6);
    cyc(1'b1, 30);
    chk("E_cp_pop1", int'(counter_p), 1034);
    idle(8);
    chk("E_cp_pop2", int'(counter_p), 1054);
    idle(8);
    chk("E_cp_pop3", int'(counter_p), 1084);
    chk("E_ur", int'(underrun), 0);

    // F: enable low mid-frame, then reset mid-frame with 2 buffered
    do_reset();
    cyc(1'b1, 7);
    idle(8);
    chk("F_cp_acc", int'(counter_p), 1031);
    cyc(1'b1, 9);
    cyc(1'b1, 11);
    enable = 1'b0;
    for (int i = 0; i < 5; i++) begin
      cyc(1'b0, 0);
      chk("F_hold_ready", int'(s_if.sample_ready), 0);
      chk("F_hold_fs", int'(frame_strobe), 0);
      chk("F_hold_cp", int'(counter_p), 1031);
    end
    enable = 1'b1;
    idle(2);
    reset = 1'b0;
    #1;
    chk("F_rst_cp", int'(counter_p), 1024);
    chk("F_rst_cn", int'(counter_n), 1024);
    cyc(1'b0, 0);
    reset = 1'b1;
    idle(7);
    chk("F_fs_e7", int'(frame_strobe), 0);
    idle(1);
    chk("F_fs_e8", int'(frame_strobe), 1);
    chk("F_ur_empty", int'(underrun), 1);
    idle(1);
    chk("F_cp_e9", int'(counter_p), 1024);

    started = 1'b0;
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule

// File: doc/counter_stream_encoder.md
# counter_stream_encoder

Transmit-side encoder that turns a stream of signed 9-bit samples (one per 3 MHz frame) into the per-cycle `counter_p`/`counter_n` count pair consumed by the decimating receive datapath at CLK_24M. It integrates each sample once and presents the running sum as a count difference. The receive chain (integrate, downsample by 2^N_DIV, double difference) then returns the original samples after a fixed latency. It is used for loopback, bring-up and stimulus generation in place of the VCO counters.

## Interface
- N_DIV, 3: log2 of CLK_24M cycles per frame; frame length F = 2^N_DIV.
- COMMON, 1024: common-mode count placed on both outputs; 12-bit unsigned.
- CLK_24M  input  1  system clock.
- reset  input  1  reset, asynchronous, active-low; clock CLK_24M.
- enable  input  1  global run enable; when low, all state holds.
- sample_in  input  9  signed sample, two's complement.
- sample_valid  input  1  sample_in valid.
- sample_ready  output  1  encoder accepts sample this cycle.
- clear_flags  input  1  synchronous clear of the underrun flag.
- counter_p  output  12  positive count, registered.
- counter_n  output  12  negative count, registered.
- frame_strobe  output  1  one-cycle pulse marking frame start, registered.
- underrun  output  1  sticky: a frame boundary found the buffer empty.

## Operation
- Phase counter `phase`, N_DIV bits, increments every enabled cycle and wraps F-1 -> 0.
- Input buffer: 2-entry FIFO.
  - sample_ready = enable && (count < 2); it is combinational from enable and registered count.
  - A push occurs when sample_valid && sample_ready.
- Frame boundary is any enabled edge with phase == F-1.
  - Pop the head into `y`, sign-extended to 12 bits.
  - If the FIFO is empty, use y = 0 and set underrun.
  - Update acc <= acc + y, 12-bit, wrapping modulo 4096 with no saturation.
- Push and pop on the same edge are both performed, and count is unchanged. When the FIFO is full, ready is low, so no push can occur.
- Outputs, every enabled edge:
  - counter_p <= (COMMON + acc) mod 4096.
  - counter_n <= COMMON.
  - Therefore counter_p - counter_n (mod 4096) = acc, and over one frame the receive integrator advances by F*acc.
- frame_strobe <= (phase == F-1) && enable, so it is high during the cycle where phase == 0.
- underrun is set at a boundary with an empty FIFO. clear_flags clears it. If set and clear happen on the same edge, set wins.
- enable low:
  - phase, FIFO, acc and outputs all hold.
  - frame_strobe is 0.
  - sample_ready is 0.
- Reset (any time, including mid-frame) values:
  - phase = 0, FIFO empty, acc = 0.
  - counter_p = counter_n = COMMON.
  - frame_strobe = 0, underrun = 0.
  - All buffered samples are discarded.

## Timing
- A sample pushed at edge t is popped at the first frame boundary at or after edge t+1.
  - acc updates on that boundary edge.
  - counter_p reflects the new acc from the following edge and holds it for F cycles.
- Push-to-pop latency:
  - Minimum 1 cycle (push at phase F-2).
  - Maximum F cycles (empty FIFO, push at phase F-1).
  - Queued samples drain one per frame.
- The first boundary after reset occurs at enabled edge F. Before that, outputs stay at COMMON.
- Sustained throughput is exactly one sample per F enabled cycles. A producer matching the frame rate never sees ready low after the first fill.
- End-to-end: with the receive datapath's 3 MHz edge aligned to frame_strobe, its channel output equals the sample sequence delayed by a constant, with underrun frames appearing as 0.

## Test plan
- Reset, enable=1, no samples:
  - counter_p = counter_n = 1024 throughout.
  - frame_strobe pulses every 8 cycles.
  - underrun sets at the first boundary (edge 8) and clear_flags drops it.
- Push 5, then zeros each frame:
  - counter_p goes 1024 -> 1029 one cycle after the boundary and stays 1029.
  - counter_n stays 1024.
- Push +1, -1, 0:
  - counter_p steps 1025 for 8 cycles, then 1024, then 1024.
- Push 255 every frame for 20 frames:
  - acc wraps modulo 4096.
  - counter_p = (1024 + 255k) mod 4096 at frame k.
  - No saturation.
- Backpressure:
  - Hold sample_valid high with 3 distinct samples inside one frame.
  - sample_ready drops after 2 pushes.
  - The third sample is accepted only after the next pop.
  - Pop order is preserved.
- enable low for 5 cycles mid-frame, then reset asserted mid-frame with 2 samples buffered:
  - During enable low, phase, outputs and ready are frozen or 0.
  - Reset returns outputs to 1024, empties the FIFO, and the next frame boundary is 8 enabled cycles after release.
